gcd_control_unit: RTL and testbench

- Control FSM that sits directly upstream of the GCD DataPath and drives its control inputs: SelectXY, loadXR, loadYR, subFlag and swapFlag.
- Sequences the subtract/swap GCD algorithm using the datapath status flags ZEQ_Flag and LEQ_Flag.
- Exposes a valid/ready start handshake to the requester and a valid/ready done handshake back to it.
- Bounds the iteration count so degenerate operand pairs cannot hang the unit.

---
 rtl/gcd_control_unit.sv | 131 +++++++++++++
 tb/tb_gcd_control_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/gcd_control_unit.sv
// Control FSM for the subtract/swap GCD datapath, with start and done valid/ready handshakes.
// Optional macro GCD_ITER_COUNT_EN adds the iter_count output (the iteration count, shown while done_valid=1).
module gcd_control_unit #(
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic              ZEQ_Flag,
  input  logic              LEQ_Flag,
  output logic              SelectXY,
  output logic              loadXR,
  output logic              loadYR,
  output logic              subFlag,
  output logic              swapFlag,
  output logic              busy,
  output logic              done_valid,
  input  logic              done_ready,
  output logic              err,
`ifdef GCD_ITER_COUNT_EN
  output logic [ITER_W-1:0] iter_count,
`endif
  output logic [2:0]        dbgState
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // start_ready is 1 only in IDLE, and done_valid is 1 only in DONE. Both are Moore outputs.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COMPARE = 3'd2,
    SWAP    = 3'd3,
    SUB     = 3'd4,
    DONE    = 3'd5
  } state_e;

  localparam logic [ITER_W-1:0] MaxIter = ITER_W'(MAX_ITER);
  localparam logic [ITER_W-1:0] IterOne = ITER_W'(1);

  state_e            state, stateNext;
  logic [ITER_W-1:0] iter, iterNext;
  logic              errReg, errNext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      iter   <= '0;
      errReg <= 1'b0;
    end else begin
      state  <= stateNext;
      iter   <= iterNext;
      errReg <= errNext;
    end
  end

  always_comb begin
    stateNext   = state;
    iterNext    = iter;
    errNext     = errReg;
    start_ready = 1'b0;
    SelectXY    = 1'b0;
    loadXR      = 1'b0;
    loadYR      = 1'b0;
    subFlag     = 1'b0;
    swapFlag    = 1'b0;
    busy        = 1'b0;
    done_valid  = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) stateNext = LOAD;
      end
      LOAD: begin
        busy      = 1'b1;
        SelectXY  = 1'b1;
        loadXR    = 1'b1;
        loadYR    = 1'b1;
        iterNext  = '0;
        errNext   = 1'b0;
        stateNext = COMPARE;
      end
      COMPARE: begin
        busy = 1'b1;
        // Equality wins over the limit check so a run that converges on its last
        // allowed iteration still reports success.
        if (ZEQ_Flag) begin
          errNext   = 1'b0;
          stateNext = DONE;
        end else if (iter == MaxIter) begin
          errNext   = 1'b1;
          stateNext = DONE;
        end else if (LEQ_Flag) begin
          stateNext = SWAP;
        end else begin
          stateNext = SUB;
        end
      end
      SWAP: begin
        busy      = 1'b1;
        swapFlag  = 1'b1;
        loadXR    = 1'b1;
        loadYR    = 1'b1;
        if (iter != MaxIter) iterNext = iter + IterOne;
        stateNext = COMPARE;
      end
      SUB: begin
        busy      = 1'b1;
        subFlag   = 1'b1;
        loadXR    = 1'b1;
        if (iter != MaxIter) iterNext = iter + IterOne;
        stateNext = COMPARE;
      end
      DONE: begin
        done_valid = 1'b1;
        if (done_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign err      = done_valid & errReg;
  assign dbgState = state;

`ifdef GCD_ITER_COUNT_EN
  assign iter_count = done_valid ? iter : '0;
`endif

endmodule

// File: tb/tb_gcd_control_unit.sv
// Directed bench for gcd_control_unit: a behavioural GCD datapath closes the loop around the FSM.
// Covers reset, normal jobs, the iteration limit, mid-job reset and a held done handshake.
module tb_gcd_control_unit;

  localparam int ITER_W = 8;
  localparam int MAX_ITER = 8;
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_CMP = 3'd2,
                         S_SWAP = 3'd3, S_SUB = 3'd4, S_DONE = 3'd5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_valid = 1'b0, done_ready = 1'b0;
  logic start_ready, ZEQ_Flag, LEQ_Flag, SelectXY, loadXR, loadYR;
  logic subFlag, swapFlag, busy, done_valid, err;
  logic [2:0] dbgState;
`ifdef GCD_ITER_COUNT_EN
  logic [ITER_W-1:0] iter_count;
`endif

  logic [7:0] xIn = '0, yIn = '0, xr = '0, yr = '0;
  logic [2:0] stateLog[$];
  int testsRun = 0, failCount = 0;
  int loadCount = 0;
  int cycles, exclViol, subSeen, stableViol;

  always #5 clk = ~clk;

  gcd_control_unit #(.ITER_W(ITER_W), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .ZEQ_Flag(ZEQ_Flag), .LEQ_Flag(LEQ_Flag), .SelectXY(SelectXY),
    .loadXR(loadXR), .loadYR(loadYR), .subFlag(subFlag), .swapFlag(swapFlag),
    .busy(busy), .done_valid(done_valid), .done_ready(done_ready), .err(err),
`ifdef GCD_ITER_COUNT_EN
    .iter_count(iter_count),
`endif
    .dbgState(dbgState)
  );

  // Behavioural datapath driven by the FSM's control outputs.
  assign ZEQ_Flag = (xr == yr);
  assign LEQ_Flag = (xr < yr);
  always @(posedge clk) begin
    if (loadXR) xr <= SelectXY ? xIn : (swapFlag ? yr : (subFlag ? xr - yr : xr));
    if (loadYR) yr <= SelectXY ? yIn : (swapFlag ? xr : yr);
  end

  always @(posedge clk) if (dbgState == S_LOAD) loadCount++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic waitDone(input int limit);
    while (!done_valid && cycles < limit) begin
      @(posedge clk); #1;
      cycles++;
      if (subFlag && swapFlag) exclViol++;
      if (!done_valid) stateLog.push_back(dbgState);
    end
  endtask

  task automatic startJob(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    xIn = x; yIn = y; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    cycles = 0; exclViol = 0;
    stateLog.delete();
    stateLog.push_back(dbgState);
  endtask

  task automatic finishJob(input string tag);
    @(negedge clk); done_ready = 1'b1;
    @(posedge clk); #1; done_ready = 1'b0;
    check({tag, "_idle_after_ack"}, dbgState, S_IDLE);
    check({tag, "_start_ready_after_ack"}, start_ready, 1);
  endtask

  task automatic checkDone(input string tag, input int lat, input logic [7:0] res,
                           input logic e, input int it);
    check({tag, "_latency"}, cycles, lat);
    check({tag, "_done_valid"}, done_valid, 1);
    check({tag, "_xr"}, xr, res);
    check({tag, "_err"}, err, e);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_start_ready"}, start_ready, 0);
    check({tag, "_excl"}, exclViol, 0);
`ifdef GCD_ITER_COUNT_EN
    check({tag, "_iter_count"}, iter_count, it);
`else
    if (it < 0) $display("unreachable");
`endif
  endtask

  logic [2:0] expSeq [12];

  initial begin
    expSeq = '{S_LOAD, S_CMP, S_SUB, S_CMP, S_SWAP, S_CMP, S_SUB, S_CMP, S_SWAP, S_CMP, S_SUB, S_CMP};

    // Reset state
    #12;
    check("rst_start_ready", start_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_loads", {loadXR, loadYR, SelectXY, subFlag, swapFlag}, 0);
    check("rst_err", err, 0);
    @(negedge clk); rst = 1'b1;

    // 25/15: five iterations
    startJob(8'd25, 8'd15);
    check("j1_load_select", {SelectXY, loadXR, loadYR}, 3'b111);
    waitDone(100);
    checkDone("j1", 12, 8'd5, 1'b0, 5);
    check("j1_seq_len", stateLog.size(), 12);
    for (int i = 0; i < 12 && i < stateLog.size(); i++)
      check($sformatf("j1_seq%0d", i), stateLog[i], expSeq[i]);
    finishJob("j1");
`ifdef GCD_ITER_COUNT_EN
    check("j1_iter_count_cleared", iter_count, 0);
`endif

    // 24/3: seven subtracts reach 3,3
    startJob(8'd24, 8'd3);
    waitDone(100);
    checkDone("j2", 16, 8'd3, 1'b0, 7);
    finishJob("j2");

    // 7/0 never converges: iteration limit
    startJob(8'd7, 8'd0);
    waitDone(100);
    checkDone("j3", 18, 8'd7, 1'b1, 8);
    finishJob("j3");
    check("j3_err_after_ack", err, 0);

    // 9/9: no iterations
    startJob(8'd9, 8'd9);
    waitDone(100);
    checkDone("j4", 2, 8'd9, 1'b0, 0);
    finishJob("j4");

    // Asynchronous reset during the third SUB of a 25/15 run
    startJob(8'd25, 8'd15);
    subSeen = 0;
    while (subSeen < 3 && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      if (dbgState == S_SUB) subSeen++;
    end
    check("ar_reached_sub3", subSeen, 3);
    #2 rst = 1'b0;
    #1;
    check("ar_state_idle", dbgState, S_IDLE);
    check("ar_outputs_zero", {loadXR, loadYR, SelectXY, subFlag, swapFlag, busy, done_valid, err}, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("ar_start_ready", start_ready, 1);
    startJob(8'd12, 8'd8);
    waitDone(100);
    checkDone("j5", 8, 8'd4, 1'b0, 3);
    finishJob("j5");

    // start_valid held high; done_ready withheld for five cycles
    @(negedge clk);
    xIn = 8'd9; yIn = 8'd9; start_valid = 1'b1;
    loadCount = 0; cycles = 0;
    waitDone(100);
    check("hold_done_reached", done_valid, 1);
    stableViol = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!done_valid || dbgState != S_DONE || start_ready || busy) stableViol++;
    end
    check("hold_done_stable", stableViol, 0);
    check("hold_one_load", loadCount, 1);
    @(negedge clk); done_ready = 1'b1;
    @(posedge clk); #1; done_ready = 1'b0;
    check("hold_idle_one_cycle", dbgState, S_IDLE);
    @(posedge clk); #1;
    check("hold_reaccept_load", dbgState, S_LOAD);
    start_valid = 1'b0;
    cycles = 0;
    waitDone(100);
    check("hold_second_done", done_valid, 1);
    finishJob("hold");
    check("hold_two_loads", loadCount, 2);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
